// File: rtl/gray_ptr_sync.sv
// Synchronizes a gray-coded pointer from a foreign clock domain and reports binary value, advance and delta.
// Optional gray-violation checking is enabled by defining GRAY_PTR_SYNC_CHECK_EN.
module gray_ptr_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clear,
    output logic             ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             advance,
    output logic [WIDTH-1:0] delta,
    output logic             err,
    output logic             err_sticky
);

    localparam int unsigned CNT_W = 3;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be within 2..4");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] g_s_bin;
    logic [WIDTH-1:0] g_prev_q, g_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             adv_q, adv_d;
    logic [WIDTH-1:0] delta_q, delta_d;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Multi-flop synchronizer; only g_s is consumed downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_s     = sync_q[STAGES-1];
    assign g_s_bin = gray2bin(g_s);

    // Priming holds off change reporting until the chain is flushed of reset zeros.
    always_comb begin
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        g_prev_d = g_s;
        bin_d    = g_s_bin;
        adv_d    = 1'b0;
        delta_d  = '0;
        if (!ready_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STAGES)) begin
                ready_d = 1'b1;
            end
        end else begin
            adv_d = (g_s != g_prev_q);
            if (adv_d) begin
                delta_d = g_s_bin - gray2bin(g_prev_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_prev_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            bin_q    <= '0;
            adv_q    <= 1'b0;
            delta_q  <= '0;
        end else begin
            g_prev_q <= g_prev_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            bin_q    <= bin_d;
            adv_q    <= adv_d;
            delta_q  <= delta_d;
        end
    end

    assign ready   = ready_q;
    assign bin_out = bin_q;
    assign advance = adv_q;
    assign delta   = delta_q;

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic [WIDTH-1:0] diff_c;
    logic             multi_c;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign diff_c  = g_s ^ g_prev_q;
    assign multi_c = |(diff_c & (diff_c - WIDTH'(1)));

    always_comb begin
        err_d    = ready_q & multi_c;
        sticky_d = sticky_q;
        if (err_clear) begin
            sticky_d = 1'b0;
        end
        if (err_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = sticky_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    assign err              = 1'b0;
    assign err_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync: directed priming/wrap/reset cases plus a randomized gray walk.
module tb_gray_ptr_sync;

    localparam int unsigned W    = 8;
    localparam int unsigned P    = 2;
    localparam int unsigned STEP = (P + 2 > 4) ? P + 2 : 4;
`ifdef GRAY_PTR_SYNC_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] gray_in;
    logic         err_clear;
    logic         ready;
    logic [W-1:0] bin_out;
    logic         advance;
    logic [W-1:0] delta;
    logic         err;
    logic         err_sticky;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] m_gray;
    logic         m_sticky;

    gray_ptr_sync #(.WIDTH(W), .STAGES(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .err_clear (err_clear),
        .ready     (ready),
        .bin_out   (bin_out),
        .advance   (advance),
        .delta     (delta),
        .err       (err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse of the gray encoding found by search over all binary values.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < (1 << W); i++) begin
            if (b2g(W'(i)) == g) r = W'(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Asynchronous reset with gray value g held, then priming observed cycle by cycle.
    task automatic do_reset(input logic [W-1:0] g);
        @(negedge clk);
        gray_in   = g;
        err_clear = 1'b0;
        #2 reset  = 1'b1;
        #1;
        check("rst_ready", W'(ready), W'(0));
        check("rst_bin", bin_out, W'(0));
        check("rst_adv", W'(advance), W'(0));
        check("rst_delta", delta, W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_sticky", W'(err_sticky), W'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= int'(P) + 3; k++) begin
            @(negedge clk);
            check("prime_ready", W'(ready), W'(k >= int'(P) + 1));
            check("prime_adv", W'(advance), W'(0));
            check("prime_delta", delta, W'(0));
            check("prime_err", W'(err), W'(0));
            if (k >= int'(P) + 1) check("prime_bin", bin_out, g2b(g));
        end
        m_gray   = g;
        m_sticky = 1'b0;
    endtask

    // Drive one gray value, hold it STEP cycles, and check every cycle against the model.
    task automatic run_step(input logic [W-1:0] ng, input bit clr_early, input bit clr_at_edge);
        logic [W-1:0] ob, nb;
        bit           chg, verr, hit;
        ob   = g2b(m_gray);
        nb   = g2b(ng);
        chg  = (ng != m_gray);
        verr = CHECK && ($countones(ng ^ m_gray) > 1);
        gray_in   = ng;
        err_clear = clr_early;
        for (int c = 1; c <= int'(STEP); c++) begin
            hit = (c == int'(P) + 1);
            if (hit && clr_at_edge) err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
            if (CHECK && c == 1 && clr_early) m_sticky = 1'b0;
            if (CHECK && hit && clr_at_edge) m_sticky = 1'b0;
            if (hit && verr) m_sticky = 1'b1;
            check("ready", W'(ready), W'(1));
            check("advance", W'(advance), W'(hit && chg));
            check("delta", delta, (hit && chg) ? W'(nb - ob) : W'(0));
            check("bin_out", bin_out, (c >= int'(P) + 1) ? nb : ob);
            check("err", W'(err), W'(hit && verr));
            check("err_sticky", W'(err_sticky), W'(m_sticky));
        end
        m_gray = ng;
    endtask

    initial begin
        logic [W-1:0] ob, nb;
        int           r;
        reset     = 1'b0;
        gray_in   = '0;
        err_clear = 1'b0;
        m_gray    = '0;
        m_sticky  = 1'b0;

        do_reset(W'(0));

        // Full gray-order walk, ending with the 255 -> 0 wrap.
        for (int i = 1; i <= 256; i++) begin
            run_step(b2g(W'(i % 256)), 1'b0, 1'b0);
        end

        for (int n = 0; n < 200; n++) begin
            r  = int'($urandom_range(0, 99));
            ob = g2b(m_gray);
            if (r < 40)      nb = ob + W'(1);
            else if (r < 70) nb = ob - W'(1);
            else if (r < 85) nb = ob;
            else             nb = W'($urandom);
            run_step(b2g(nb), ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Reset mid-run with a fresh value pending across release.
        do_reset(W'(8'h5A));
        check("bin_5a", bin_out, W'(8'h6C));
        run_step(W'(8'h5A), 1'b0, 1'b0);

        // Two-bit jump, clear, then violation coinciding with clear.
        do_reset(W'(0));
        run_step(W'(8'h03), 1'b0, 1'b0);
        run_step(W'(8'h03), 1'b1, 1'b0);
        run_step(W'(8'h00), 1'b0, 1'b1);
        run_step(W'(8'h00), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
